uart_rx_packetiser: RTL and testbench

Frames the raw byte stream from the UART receiver into addressed packets for the register layer. Each packet on the wire is a sync byte, destination, source, length and payload bytes. The block removes the framing and emits one output beat per payload byte, tagged with destination, source, length, start-of-packet and end-of-packet. It also recovers from truncated frames using an inter-byte timeout.

---
 rtl/uart_rx_packetiser.sv | 147 ++++++++++++++
 tb/tb_uart_rx_packetiser.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packetiser.sv
// uart_rx_packetiser: turns a raw UART byte stream into addressed packets.
// Strips sync/dest/src/len header, emits one tagged beat per payload byte.
module uart_rx_packetiser #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opDestination,
  output logic [7:0] opSource,
  output logic [7:0] opLength,
  output logic [7:0] opData,
  output logic       opSoP,
  output logic       opEoP,
  output logic       opValid,
  output logic       opAbort
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_FIRE = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [CW-1:0] TO_SAT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    LEN,
    DATA
  } state_t;

  state_t state;
  state_t stateNext;

  logic [CW-1:0] toCnt;
  logic [7:0] remCnt;
  logic [7:0] remNext;
  logic [7:0] destNext;
  logic [7:0] srcNext;
  logic [7:0] lenNext;
  logic [7:0] dataNext;
  logic validNext;
  logic sopNext;
  logic eopNext;
  logic abortNext;
  logic timeout;

  // A byte on the timeout cycle wins, so only idle cycles can expire.
  assign timeout = (state != IDLE) && !ipRxValid
                   && (toCnt == TO_FIRE);

  // Inter-byte idle counter; only counts while a frame is open.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      toCnt <= '0;
    end else if (ipRxValid || state == IDLE || timeout) begin
      toCnt <= '0;
    end else if (toCnt != TO_SAT) begin
      toCnt <= toCnt + 1'b1;
    end
  end

  // State, payload down-counter and registered outputs.
  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state         <= IDLE;
      remCnt        <= '0;
      opDestination <= '0;
      opSource      <= '0;
      opLength      <= '0;
      opData        <= '0;
      opSoP         <= 1'b0;
      opEoP         <= 1'b0;
      opValid       <= 1'b0;
      opAbort       <= 1'b0;
    end else begin
      state         <= stateNext;
      remCnt        <= remNext;
      opDestination <= destNext;
      opSource      <= srcNext;
      opLength      <= lenNext;
      opData        <= dataNext;
      opSoP         <= sopNext;
      opEoP         <= eopNext;
      opValid       <= validNext;
      opAbort       <= abortNext;
    end
  end

  // Frame parser: next state, header capture and beat generation.
  always_comb begin
    stateNext = state;
    remNext   = remCnt;
    destNext  = opDestination;
    srcNext   = opSource;
    lenNext   = opLength;
    dataNext  = opData;
    validNext = 1'b0;
    sopNext   = 1'b0;
    eopNext   = 1'b0;
    abortNext = 1'b0;
    if (ipRxValid) begin
      unique case (state)
        IDLE: begin
          if (ipRxData == SYNC_BYTE) begin
            stateNext = DEST;
          end
        end
        DEST: begin
          destNext  = ipRxData;
          stateNext = SRC;
        end
        SRC: begin
          srcNext   = ipRxData;
          stateNext = LEN;
        end
        LEN: begin
          lenNext = ipRxData;
          remNext = ipRxData;
          if (ipRxData == 8'd0) begin
            stateNext = IDLE;
          end else begin
            stateNext = DATA;
          end
        end
        DATA: begin
          validNext = 1'b1;
          dataNext  = ipRxData;
          sopNext   = (remCnt == opLength);
          eopNext   = (remCnt == 8'd1);
          remNext   = remCnt - 8'd1;
          if (remCnt == 8'd1) begin
            stateNext = IDLE;
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end else if (timeout) begin
      stateNext = IDLE;
      abortNext = (state == DATA);
    end
  end

endmodule

// File: tb/tb_uart_rx_packetiser.sv
// tb_uart_rx_packetiser: scenario tasks plus random frames, each
// checked against a byte-level frame model with cycle timestamps.
module tb_uart_rx_packetiser;

  localparam int TO = 20;

  typedef struct packed {
    logic [31:0] cyc;
    logic        abort;
    logic        sop;
    logic        eop;
    logic [7:0]  data;
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [7:0]  len;
  } ev_t;

  typedef struct {
    int         at;
    logic [7:0] b;
    bit         rst;
  } stim_t;

  logic       ipClk = 1'b0;
  logic       ipReset = 1'b0;
  logic [7:0] ipRxData = 8'h00;
  logic       ipRxValid = 1'b0;
  logic [7:0] opDestination;
  logic [7:0] opSource;
  logic [7:0] opLength;
  logic [7:0] opData;
  logic       opSoP;
  logic       opEoP;
  logic       opValid;
  logic       opAbort;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int hygBad = 0;
  stim_t stimQ[$];
  ev_t actQ[$];
  ev_t expQ[$];

  uart_rx_packetiser #(
    .SYNC_BYTE(8'h55),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ipClk(ipClk),
    .ipReset(ipReset),
    .ipRxData(ipRxData),
    .ipRxValid(ipRxValid),
    .opDestination(opDestination),
    .opSource(opSource),
    .opLength(opLength),
    .opData(opData),
    .opSoP(opSoP),
    .opEoP(opEoP),
    .opValid(opValid),
    .opAbort(opAbort)
  );

  always #5 ipClk = ~ipClk;

  always @(posedge ipClk) cyc++;

  always @(negedge ipClk) begin
    if (opValid || opAbort)
      actQ.push_back('{cyc: cyc, abort: opAbort, sop: opSoP,
                       eop: opEoP, data: opValid ? opData : 8'h00,
                       dest: opDestination, src: opSource,
                       len: opLength});
    if ((opValid && opAbort) || (!opValid && (opSoP || opEoP)))
      hygBad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time expired, want finish");
    $fatal(1);
  end

  function automatic string evStr(ev_t e);
    return $sformatf("{c=%0d ab=%0b sop=%0b eop=%0b d=%h dst=%h src=%h len=%h}",
                     e.cyc, e.abort, e.sop, e.eop, e.data, e.dest,
                     e.src, e.len);
  endfunction

  task automatic sendByte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge ipClk);
    ipRxValid = 1'b1;
    ipRxData = b;
    stimQ.push_back('{at: cyc + 1, b: b, rst: 1'b0});
    @(negedge ipClk);
    ipRxValid = 1'b0;
    ipRxData = 8'($urandom);
  endtask

  task automatic startScenario();
    stimQ.delete();
    actQ.delete();
    hygBad = 0;
  endtask

  task automatic endScenario();
    repeat (TO + 5) @(negedge ipClk);
  endtask

  // Frame model: walks the byte list by field position, with timeouts
  // derived from the edge distance between consecutive bytes.
  task automatic buildExpected();
    int idx = 0;
    int last = 0;
    int pos = 0;
    logic [7:0] d = 8'h00;
    logic [7:0] s = 8'h00;
    logic [7:0] l = 8'h00;
    expQ.delete();
    foreach (stimQ[i]) begin
      if (idx != 0 && stimQ[i].at - last >= TO) begin
        if (idx == 4)
          expQ.push_back('{cyc: last + TO - 1, abort: 1'b1, sop: 1'b0,
                           eop: 1'b0, data: 8'h00, dest: d, src: s,
                           len: l});
        idx = 0;
      end
      if (stimQ[i].rst) begin
        idx = 0;
      end else begin
        last = stimQ[i].at;
        case (idx)
          0: if (stimQ[i].b == 8'h55) idx = 1;
          1: begin d = stimQ[i].b; idx = 2; end
          2: begin s = stimQ[i].b; idx = 3; end
          3: begin
            l = stimQ[i].b;
            pos = 0;
            idx = (l == 0) ? 0 : 4;
          end
          default: begin
            expQ.push_back('{cyc: stimQ[i].at, abort: 1'b0,
                             sop: pos == 0, eop: pos == int'(l) - 1,
                             data: stimQ[i].b, dest: d, src: s,
                             len: l});
            pos++;
            if (pos == int'(l)) idx = 0;
          end
        endcase
      end
    end
    if (idx == 4)
      expQ.push_back('{cyc: last + TO - 1, abort: 1'b1, sop: 1'b0,
                       eop: 1'b0, data: 8'h00, dest: d, src: s, len: l});
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ipClk);
    total++;
    if ({opDestination, opSource, opLength, opData} !== 32'h0)
      $display("FAIL reset fields: got %h want 0",
               {opDestination, opSource, opLength, opData});
    else passed++;
    total++;
    if ({opSoP, opEoP, opValid, opAbort} !== 4'b0)
      $display("FAIL reset pulses: got %b want 0000",
               {opSoP, opEoP, opValid, opAbort});
    else passed++;
    ipReset = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] fr[7] = '{8'h55, 8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    startScenario();
    foreach (fr[i]) sendByte(fr[i], (i == 0) ? 0 : 9);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL basic count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL basic ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    if (actQ.size() == 3) begin
      total++;
      if ({actQ[0].data, actQ[1].data, actQ[2].data,
           actQ[0].sop, actQ[1].sop, actQ[2].sop,
           actQ[0].eop, actQ[1].eop, actQ[2].eop,
           actQ[0].dest, actQ[0].src, actQ[0].len}
          !== {24'hAABBCC, 3'b100, 3'b001, 24'h010203})
        $display("FAIL basic fields: got %s %s %s want AA/BB/CC sop-first eop-last",
                 evStr(actQ[0]), evStr(actQ[1]), evStr(actQ[2]));
      else passed++;
    end
    total++;
    if (hygBad !== 0) $display("FAIL basic pulses: got %0d bad want 0", hygBad);
    else passed++;
  endtask

  task automatic test_garbage();
    logic [7:0] fr[8] = '{8'h00, 8'hFF, 8'h12, 8'h55, 8'h10, 8'h20,
                          8'h01, 8'h5A};
    startScenario();
    foreach (fr[i]) sendByte(fr[i], 4);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL garbage count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL garbage ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    if (actQ.size() == 1) begin
      total++;
      if ({actQ[0].data, actQ[0].sop, actQ[0].eop, actQ[0].abort}
          !== {8'h5A, 3'b110})
        $display("FAIL garbage beat: got %s want d=5a sop=1 eop=1", evStr(actQ[0]));
      else passed++;
    end
    total++;
    if (hygBad !== 0) $display("FAIL garbage pulses: got %0d bad want 0", hygBad);
    else passed++;
  endtask

  task automatic test_zero_len();
    logic [7:0] fr[9] = '{8'h55, 8'h01, 8'h02, 8'h00, 8'h55, 8'h01,
                          8'h02, 8'h01, 8'h55};
    startScenario();
    foreach (fr[i]) sendByte(fr[i], 6);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL zerolen count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL zerolen ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    if (actQ.size() == 1) begin
      total++;
      if ({actQ[0].data, actQ[0].abort, actQ[0].sop, actQ[0].eop}
          !== {8'h55, 3'b011})
        $display("FAIL zerolen beat: got %s want single d=55 beat", evStr(actQ[0]));
      else passed++;
    end
    total++;
    if (hygBad !== 0) $display("FAIL zerolen pulses: got %0d bad want 0", hygBad);
    else passed++;
  endtask

  task automatic test_timeout();
    logic [7:0] fr[6] = '{8'h55, 8'h01, 8'h02, 8'h04, 8'h11, 8'h22};
    logic [7:0] f2[5] = '{8'h55, 8'h07, 8'h08, 8'h01, 8'h99};
    int nAbort = 0;
    int abCyc = 0;
    int byteAt;
    startScenario();
    foreach (fr[i]) sendByte(fr[i], 5);
    byteAt = stimQ[5].at;
    endScenario();
    foreach (f2[i]) sendByte(f2[i], 3);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL timeout count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL timeout ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    foreach (actQ[i]) if (actQ[i].abort) begin
      nAbort++;
      abCyc = int'(actQ[i].cyc);
    end
    total++;
    if (nAbort !== 1 || abCyc - byteAt !== TO - 1)
      $display("FAIL timeout abort: got %0d aborts at +%0d want 1 at +%0d",
               nAbort, abCyc - byteAt, TO - 1);
    else passed++;
    total++;
    if (hygBad !== 0) $display("FAIL timeout pulses: got %0d bad want 0", hygBad);
    else passed++;
  endtask

  task automatic test_timeout_edge();
    logic [7:0] fr[7] = '{8'h55, 8'h31, 8'h32, 8'h03, 8'h11, 8'h22, 8'h33};
    int nAbort = 0;
    startScenario();
    foreach (fr[i]) sendByte(fr[i], (i >= 5) ? TO - 2 : 2);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL toedge count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL toedge ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    foreach (actQ[i]) if (actQ[i].abort) nAbort++;
    total++;
    if (nAbort !== 0 || actQ.size() !== 3)
      $display("FAIL toedge abort: got %0d aborts %0d events want 0 and 3",
               nAbort, actQ.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] f2[6] = '{8'h55, 8'h0A, 8'h0B, 8'h02, 8'hE1, 8'hE2};
    startScenario();
    sendByte(8'h55, 0);
    sendByte(8'h01, 3);
    ipReset = 1'b0;
    stimQ.push_back('{at: cyc + 1, b: 8'h00, rst: 1'b1});
    #1;
    total++;
    if ({opDestination, opSource, opLength, opData,
         opSoP, opEoP, opValid, opAbort} !== 36'h0)
      $display("FAIL resetmid outputs: got dst=%h src=%h len=%h d=%h want all 0",
               opDestination, opSource, opLength, opData);
    else passed++;
    @(negedge ipClk);
    ipReset = 1'b1;
    sendByte(8'h02, 2);
    sendByte(8'h03, 2);
    sendByte(8'hAB, 2);
    foreach (f2[i]) sendByte(f2[i], 2);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL resetmid count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL resetmid ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fr[11] = '{8'h55, 8'hA1, 8'hB2, 8'h02, 8'h10, 8'h20,
                           8'h55, 8'hC3, 8'hD4, 8'h01, 8'h30};
    startScenario();
    foreach (fr[i]) sendByte(fr[i], 0);
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL b2b count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL b2b ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
  endtask

  task automatic test_random();
    startScenario();
    for (int f = 0; f < 30; f++) begin
      int len = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) sendByte(8'($urandom), $urandom_range(0, 5));
      sendByte(8'h55, $urandom_range(0, 8));
      for (int k = 0; k < len + 3; k++) begin
        logic [7:0] b = (k == 2) ? 8'(len) : 8'($urandom);
        int gap = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 3, TO + 1)
                                               : $urandom_range(0, 10);
        sendByte(b, gap);
      end
    end
    endScenario();
    buildExpected();
    total++;
    if (actQ.size() !== expQ.size())
      $display("FAIL random count: got %0d want %0d", actQ.size(), expQ.size());
    else passed++;
    foreach (expQ[i]) begin
      ev_t a = (i < actQ.size()) ? actQ[i] : '0;
      total++;
      if (a !== expQ[i])
        $display("FAIL random ev%0d: got %s want %s", i, evStr(a), evStr(expQ[i]));
      else passed++;
    end
    total++;
    if (hygBad !== 0) $display("FAIL random pulses: got %0d bad want 0", hygBad);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_zero_len();
    test_timeout();
    test_timeout_edge();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
